// File: rtl/dac_stream_arbiter_pkg.sv
// Shared definitions for the two-channel DAC stream arbiter:
// the arbitration FSM states and the channel encoding used on asoChannel.
package drvAd56x3Pkg;

    typedef enum logic [1:0] {
        RR     = 2'd0,
        PAIR_A = 2'd1,
        PAIR_B = 2'd2
    } arb_state_e;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

endpackage

// File: rtl/dac_stream_arbiter.sv
// Merges two Avalon-ST sample streams (A, B) onto one registered source,
// either round-robin or as strictly paired A-then-B updates.
module dac_stream_arbiter
    import drvAd56x3Pkg::*;
#(
    parameter int DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  paired,
    input  logic                  asiAValid,
    input  logic [DATA_WIDTH-1:0] asiAData,
    output logic                  asiARdy,
    input  logic                  asiBValid,
    input  logic [DATA_WIDTH-1:0] asiBData,
    output logic                  asiBRdy,
    output logic                  asoValid,
    output logic                  asoChannel,
    output logic [DATA_WIDTH-1:0] asoData,
    input  logic                  asoRdy,
    output logic [15:0]           cntA,
    output logic [15:0]           cntB
);

    arb_state_e            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  aso_valid_q, aso_valid_d;
    logic                  aso_channel_q, aso_channel_d;
    logic [DATA_WIDTH-1:0] aso_data_q, aso_data_d;
    logic [15:0]           cnt_a_q, cnt_a_d;
    logic [15:0]           cnt_b_q, cnt_b_d;

    logic grant_vld;
    logic grant_ch;
    logic accept;
    logic fire;

    // Eligibility per state; in RR a tie goes to the channel not served last.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = CH_A;
        unique case (state_q)
            RR: begin
                if (!paired) begin
                    if (asiAValid && asiBValid) begin
                        grant_vld = 1'b1;
                        grant_ch  = (last_grant_q == CH_A) ? CH_B : CH_A;
                    end else if (asiAValid) begin
                        grant_vld = 1'b1;
                        grant_ch  = CH_A;
                    end else if (asiBValid) begin
                        grant_vld = 1'b1;
                        grant_ch  = CH_B;
                    end
                end
            end
            PAIR_A: begin
                grant_vld = asiAValid;
                grant_ch  = CH_A;
            end
            PAIR_B: begin
                grant_vld = asiBValid;
                grant_ch  = CH_B;
            end
            default: begin
                grant_vld = 1'b0;
                grant_ch  = CH_A;
            end
        endcase
    end

    assign accept  = (!aso_valid_q || asoRdy) && grant_vld && !reset;
    assign asiARdy = accept && (grant_ch == CH_A);
    assign asiBRdy = accept && (grant_ch == CH_B);
    assign fire    = aso_valid_q && asoRdy;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RR: begin
                if (paired) begin
                    state_d = PAIR_A;
                end
            end
            PAIR_A: begin
                if (accept) begin
                    state_d = PAIR_B;
                end else if (!paired) begin
                    state_d = RR;
                end
            end
            // A started pair always completes, whatever paired does meanwhile.
            PAIR_B: begin
                if (accept) begin
                    state_d = paired ? PAIR_A : RR;
                end
            end
            default: begin
                state_d = RR;
            end
        endcase
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        aso_valid_d   = aso_valid_q;
        aso_channel_d = aso_channel_q;
        aso_data_d    = aso_data_q;
        cnt_a_d       = cnt_a_q;
        cnt_b_d       = cnt_b_q;

        if (accept) begin
            last_grant_d  = grant_ch;
            aso_valid_d   = 1'b1;
            aso_channel_d = grant_ch;
            aso_data_d    = (grant_ch == CH_B) ? asiBData : asiAData;
        end else if (asoRdy) begin
            aso_valid_d   = 1'b0;
        end

        if (fire && (aso_channel_q == CH_A)) begin
            cnt_a_d = cnt_a_q + 16'd1;
        end
        if (fire && (aso_channel_q == CH_B)) begin
            cnt_b_d = cnt_b_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RR;
            last_grant_q  <= CH_B;
            aso_valid_q   <= 1'b0;
            aso_channel_q <= CH_A;
            aso_data_q    <= '0;
            cnt_a_q       <= 16'd0;
            cnt_b_q       <= 16'd0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            aso_valid_q   <= aso_valid_d;
            aso_channel_q <= aso_channel_d;
            aso_data_q    <= aso_data_d;
            cnt_a_q       <= cnt_a_d;
            cnt_b_q       <= cnt_b_d;
        end
    end

    assign asoValid   = aso_valid_q;
    assign asoChannel = aso_channel_q;
    assign asoData    = aso_data_q;
    assign cntA       = cnt_a_q;
    assign cntB       = cnt_b_q;

endmodule

// File: tb/tb_dac_stream_arbiter.sv
// Scoreboard bench for dac_stream_arbiter: expected {channel,data} pushed
// when stimulus is set up, popped and compared on each output transfer.
module tb_dac_stream_arbiter;

    localparam int DW = 14;

    logic          clk;
    logic          reset;
    logic          paired;
    logic          asiAValid;
    logic [DW-1:0] asiAData;
    logic          asiARdy;
    logic          asiBValid;
    logic [DW-1:0] asiBData;
    logic          asiBRdy;
    logic          asoValid;
    logic          asoChannel;
    logic [DW-1:0] asoData;
    logic          asoRdy;
    logic [15:0]   cntA;
    logic [15:0]   cntB;

    dac_stream_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .paired     (paired),
        .asiAValid  (asiAValid),
        .asiAData   (asiAData),
        .asiARdy    (asiARdy),
        .asiBValid  (asiBValid),
        .asiBData   (asiBData),
        .asiBRdy    (asiBRdy),
        .asoValid   (asoValid),
        .asoChannel (asoChannel),
        .asoData    (asoData),
        .asoRdy     (asoRdy),
        .cntA       (cntA),
        .cntB       (cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW:0]   sb[$];
    logic [DW-1:0] a_base, b_base;
    int            a_sent, b_sent, a_limit, b_limit;
    int            n;

    task automatic chk_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic ch, input logic [DW-1:0] d);
        sb.push_back({ch, d});
    endtask

    task automatic start_a(input logic [DW-1:0] base, input int limit);
        a_base    = base;
        a_sent    = 0;
        a_limit   = limit;
        asiAData  = base;
        asiAValid = (limit > 0);
    endtask

    task automatic start_b(input logic [DW-1:0] base, input int limit);
        b_base    = base;
        b_sent    = 0;
        b_limit   = limit;
        asiBData  = base;
        asiBValid = (limit > 0);
    endtask

    // One clock: sample handshakes and output at negedge, advance sources after posedge.
    task automatic step();
        logic        a_hs, b_hs;
        logic [DW:0] e;
        @(negedge clk);
        a_hs = asiAValid && asiARdy;
        b_hs = asiBValid && asiBRdy;
        if (asoValid && asoRdy && !reset) begin
            if (sb.size() == 0) begin
                chk_eq("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk_eq("out_ch", int'(asoChannel), int'(e[DW]));
                chk_eq("out_data", int'(asoData), int'(e[DW-1:0]));
            end
        end
        @(posedge clk);
        #1;
        if (a_hs) begin
            a_sent++;
            asiAData = a_base + a_sent[DW-1:0];
            if (a_sent >= a_limit) asiAValid = 1'b0;
        end
        if (b_hs) begin
            b_sent++;
            asiBData = b_base + b_sent[DW-1:0];
            if (b_sent >= b_limit) asiBValid = 1'b0;
        end
    endtask

    task automatic drain(input int maxc, output int cycles);
        cycles = 0;
        while (sb.size() != 0 && cycles < maxc) begin
            step();
            cycles++;
        end
        chk_eq("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        asiAValid = 1'b0;
        asiBValid = 1'b0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset     = 1'b1;
        paired    = 1'b0;
        asoRdy    = 1'b1;
        asiAValid = 1'b0;
        asiBValid = 1'b0;
        asiAData  = '0;
        asiBData  = '0;

        // Reset state, with both inputs valid: no ready may escape.
        start_a(14'h1000, 8);
        start_b(14'h2000, 8);
        step();
        step();
        chk_eq("rst_aso_valid", int'(asoValid), 0);
        chk_eq("rst_aso_ch", int'(asoChannel), 0);
        chk_eq("rst_aso_data", int'(asoData), 0);
        chk_eq("rst_cnt_a", int'(cntA), 0);
        chk_eq("rst_cnt_b", int'(cntB), 0);
        chk_eq("rst_a_rdy", int'(asiARdy), 0);
        chk_eq("rst_b_rdy", int'(asiBRdy), 0);

        // Round robin with both valid: A wins first tie, then alternate.
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 14'h1000 + 14'(i));
            push(1'b1, 14'h2000 + 14'(i));
        end
        reset = 1'b0;
        chk_eq("rr_vld_pre", int'(asoValid), 0);
        step();
        chk_eq("rr_first_vld", int'(asoValid), 1);
        chk_eq("rr_first_ch", int'(asoChannel), 0);
        drain(40, n);
        chk_eq("rr_cycles", n, 16);
        chk_eq("rr_cnt_a", int'(cntA), 8);
        chk_eq("rr_cnt_b", int'(cntB), 8);

        // Backpressure hold: 0x3FFF stays put while the sink stalls.
        do_reset();
        asoRdy = 1'b0;
        start_a(14'h3FFF, 2);
        push(1'b0, 14'h3FFF);
        push(1'b0, 14'h0000);
        step();
        for (int i = 0; i < 5; i++) begin
            chk_eq("hold_vld", int'(asoValid), 1);
            chk_eq("hold_data", int'(asoData), 'h3FFF);
            chk_eq("hold_a_rdy", int'(asiARdy), 0);
            step();
        end
        asoRdy = 1'b1;
        step();
        chk_eq("hold_cnt_a1", int'(cntA), 1);
        drain(10, n);
        chk_eq("hold_cnt_a", int'(cntA), 2);
        chk_eq("hold_cnt_b", int'(cntB), 0);

        // Paired mode: B alone is never sent; A then B back to back.
        do_reset();
        paired = 1'b1;
        start_b(14'h2AAA, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_eq("pair_b_only_vld", int'(asoValid), 0);
        end
        push(1'b0, 14'h1555);
        push(1'b1, 14'h2AAA);
        start_a(14'h1555, 1);
        drain(20, n);
        chk_eq("pair_cycles", n, 3);
        chk_eq("pair_cnt_a", int'(cntA), 1);
        chk_eq("pair_cnt_b", int'(cntB), 1);

        // paired drops inside PAIR_B while B stalls: B still completes first.
        do_reset();
        paired = 1'b1;
        start_a(14'h0123, 2);
        push(1'b0, 14'h0123);
        step();
        step();
        paired = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("pb_stall_vld", int'(asoValid), 0);
        end
        push(1'b1, 14'h0456);
        push(1'b0, 14'h0124);
        start_b(14'h0456, 1);
        drain(20, n);
        chk_eq("pb_cycles", n, 3);
        chk_eq("pb_cnt_a", int'(cntA), 2);
        chk_eq("pb_cnt_b", int'(cntB), 1);

        // Reset while a sample is held: it must vanish.
        do_reset();
        asoRdy = 1'b0;
        start_a(14'h0ABC, 1);
        step();
        chk_eq("mid_vld", int'(asoValid), 1);
        chk_eq("mid_data", int'(asoData), 'h0ABC);
        reset = 1'b1;
        step();
        chk_eq("mid_rst_vld", int'(asoValid), 0);
        reset  = 1'b0;
        asoRdy = 1'b1;
        repeat (4) step();
        chk_eq("mid_after_vld", int'(asoValid), 0);
        chk_eq("mid_cnt_a", int'(cntA), 0);
        chk_eq("mid_cnt_b", int'(cntB), 0);

        // 65537 A transfers at full rate: counter wraps to 1.
        do_reset();
        asoRdy = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            push(1'b0, 14'(i));
        end
        start_a(14'h0000, 65537);
        drain(70000, n);
        chk_eq("wrap_cycles", n, 65538);
        chk_eq("wrap_cnt_a", int'(cntA), 1);
        chk_eq("wrap_cnt_b", int'(cntB), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
